cache_opr_sequencer: RTL and testbench
======================================

CACHE_OPR_SEQUENCER -- requirements
Module: cache_opr_sequencer

Interface
REQ-001 SHALL have parameter NUM_OPR, default 8: number of sequenced cache operation stages (1..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: maximum WAIT cycles per stage before abort (1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port valid  input  1  command request.
REQ-006 SHALL have port ready  output  1  sequencer can accept a command.
REQ-007 SHALL have port opr_mask  input  NUM_OPR  stages to run for this command; bit i set means run stage i.
REQ-008 SHALL have port opr_start  output  NUM_OPR  one-hot, one-cycle start pulse to stage i.
REQ-009 SHALL have port opr_done  input  NUM_OPR  completion pulse from stage i.
REQ-010 SHALL have port opr_active  output  NUM_OPR  one-hot level while stage i is outstanding.
REQ-011 SHALL have port cur_opr  output  3  index of the current or last issued stage.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port opr_finished  output  1  one-cycle pulse at command completion.
REQ-014 SHALL have port opr_error  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE; ready = (state==IDLE).
REQ-016 SHALL accept a command on valid&&ready, latch opr_mask into a pending register and clear opr_error.
REQ-017 SHALL go IDLE->ISSUE on acceptance with a nonzero mask, and IDLE->DONE with a zero mask.
REQ-018 In ISSUE, SHALL select the lowest set pending bit, load cur_opr with its index, pulse opr_start[idx] for exactly 1 cycle, and go to WAIT.
REQ-019 SHALL issue stages strictly in ascending index order, one outstanding at a time; unmasked stages never see opr_start.
REQ-020 In WAIT, SHALL hold opr_active[cur_opr]=1 and sample only opr_done[cur_opr]; done bits on other indices SHALL be ignored.
REQ-021 On opr_done[cur_opr] in WAIT, SHALL clear that pending bit, then go to ISSUE if pending is nonzero, else DONE.
REQ-022 SHALL ignore opr_done asserted in the ISSUE cycle (same cycle as opr_start).
REQ-023 In DONE, SHALL assert opr_finished for 1 cycle and return to IDLE; valid SHALL be ignored while busy.
REQ-024 Latency: accept at cycle 0 -> opr_start at cycle 1; done at cycle k -> next opr_start at k+1, or opr_finished at k+1; ready high at k+2.
REQ-025 With a zero mask, opr_finished SHALL pulse at cycle 1 and no opr_start SHALL be issued.

Reset
REQ-026 On rst, SHALL enter IDLE with pending=0, cur_opr=0, opr_start=0, opr_active=0, busy=0, opr_finished=0, opr_error=0, timeout counter=0, and ready=1 in the following cycle.
REQ-027 rst asserted mid-command SHALL abandon the command without emitting opr_finished.

Configuration
REQ-028 With OPR_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle; if it reaches TIMEOUT_CYC without done, SHALL set opr_error, drop pending and go to DONE (opr_finished still pulses).
REQ-029 With OPR_TIMEOUT_EN defined, a done in the same cycle the counter reaches TIMEOUT_CYC SHALL win (no error).
REQ-030 Without OPR_TIMEOUT_EN, WAIT SHALL wait indefinitely, opr_error SHALL be tied to 0, and no counter SHALL be synthesised.

Structure
REQ-031 Package cache_opr_pkg SHALL hold the state enum typedef, NUM_OPR_MAX=8, and TIMEOUT_CYC_DEF=255.
REQ-032 Lowest-set-bit selection SHALL be a sub-module cache_opr_prio_enc (mask in, index plus found out).

Verification
REQ-033 The bench SHALL cover: mask=8'hFF, each done 3 cycles after its start -> starts on idx 0..7 in order, opr_finished at cycle 33.
REQ-034 The bench SHALL cover: mask=8'b1010_0100 -> starts only on idx 2, 5, 7; opr_active is never set on other bits.
REQ-035 The bench SHALL cover: mask=0 -> opr_finished at cycle 1, opr_start stays 0, ready=1 at cycle 2.
REQ-036 The bench SHALL cover: mask=8'h03 with opr_done[1] pulsed while waiting on idx 0 -> ignored; idx 1 is started only after opr_done[0].
REQ-037 The bench SHALL cover, with OPR_TIMEOUT_EN and TIMEOUT_CYC=4: stage 0 never done -> opr_error=1 and opr_finished 1 cycle after the 4th WAIT cycle; the next accepted command clears opr_error.
REQ-038 The bench SHALL cover: rst pulsed while in WAIT on idx 3 -> all outputs return to reset values the next cycle, with no opr_finished.

Source files
------------

// File: rtl/cache_opr_pkg.sv
// Shared types and limits for the cache operation sequencer.
// Holds the FSM state enum and the stage-count / timeout defaults.
package cache_opr_pkg;

    localparam int NUM_OPR_MAX     = 8;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } opr_state_e;

endpackage

// File: rtl/cache_opr_sequencer_if.sv
// Command and stage handshake bundle for the cache operation sequencer.
// master: command source and stage responders; slave: the sequencer.
interface cache_opr_sequencer_if #(
    parameter int NUM_OPR = 8
);
    logic               valid;
    logic               ready;
    logic [NUM_OPR-1:0] opr_mask;
    logic [NUM_OPR-1:0] opr_start;
    logic [NUM_OPR-1:0] opr_done;
    logic [NUM_OPR-1:0] opr_active;
    logic [2:0]         cur_opr;
    logic               busy;
    logic               opr_finished;
    logic               opr_error;

    modport master (
        output valid,
        output opr_mask,
        output opr_done,
        input  ready,
        input  opr_start,
        input  opr_active,
        input  cur_opr,
        input  busy,
        input  opr_finished,
        input  opr_error
    );

    modport slave (
        input  valid,
        input  opr_mask,
        input  opr_done,
        output ready,
        output opr_start,
        output opr_active,
        output cur_opr,
        output busy,
        output opr_finished,
        output opr_error
    );

endinterface

// File: rtl/cache_opr_prio_enc.sv
// Lowest-set-bit priority encoder for the pending stage mask.
// Ports: mask_i (W), idx_o (3, index of lowest set bit), found_o.
module cache_opr_prio_enc
    import cache_opr_pkg::*;
#(
    parameter int W = NUM_OPR_MAX
) (
    input  logic [W-1:0] mask_i,
    output logic [2:0]   idx_o,
    output logic         found_o
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o   = 3'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_opr_sequencer.sv
// Issues masked cache operation stages one at a time, lowest index first.
// Ports: clk, rst (sync, active-high), opr_if (slave: valid/ready command,
// opr_mask, opr_start/opr_done/opr_active per stage, cur_opr, busy,
// opr_finished, opr_error). Define OPR_TIMEOUT_EN to abort stalled stages.
module cache_opr_sequencer
    import cache_opr_pkg::*;
#(
    parameter int NUM_OPR     = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_opr_sequencer_if.slave  opr_if
);

    opr_state_e         state_q;
    logic [NUM_OPR-1:0] pend_q;
    logic [NUM_OPR-1:0] start_q;
    logic [NUM_OPR-1:0] active_q;
    logic [2:0]         cur_q;
    logic               fin_q;

    logic [NUM_OPR-1:0] pend_d;
    logic [2:0]         nx_idx;
    logic               nx_found;
    logic               done_hit;

    function automatic logic [NUM_OPR-1:0] onehot(input logic [2:0] idx);
        logic [NUM_OPR-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Only the done of the stage currently waited on counts.
    assign done_hit = (state_q == ST_WAIT) && opr_if.opr_done[cur_q];

    // Pending mask as it will be after this edge; the encoder looks
    // ahead so the next start pulse and cur_opr can be registered.
    always_comb begin
        pend_d = pend_q;
        if (state_q == ST_IDLE && opr_if.valid) begin
            pend_d = opr_if.opr_mask;
        end else if (done_hit) begin
            pend_d = pend_q & ~onehot(cur_q);
        end
    end

    cache_opr_prio_enc #(
        .W (NUM_OPR)
    ) u_prio_enc (
        .mask_i  (pend_d),
        .idx_o   (nx_idx),
        .found_o (nx_found)
    );

`ifdef OPR_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            start_q  <= '0;
            active_q <= '0;
            cur_q    <= '0;
            fin_q    <= 1'b0;
`ifdef OPR_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            start_q <= '0;
            fin_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (opr_if.valid) begin
                        pend_q <= opr_if.opr_mask;
`ifdef OPR_TIMEOUT_EN
                        err_q  <= 1'b0;
`endif
                        if (nx_found) begin
                            state_q <= ST_ISSUE;
                            cur_q   <= nx_idx;
                            start_q <= onehot(nx_idx);
                        end else begin
                            state_q <= ST_DONE;
                            fin_q   <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q  <= ST_WAIT;
                    active_q <= onehot(cur_q);
`ifdef OPR_TIMEOUT_EN
                    cnt_q    <= '0;
`endif
                end
                ST_WAIT: begin
                    if (done_hit) begin
                        pend_q   <= pend_d;
                        active_q <= '0;
                        if (nx_found) begin
                            state_q <= ST_ISSUE;
                            cur_q   <= nx_idx;
                            start_q <= onehot(nx_idx);
                        end else begin
                            state_q <= ST_DONE;
                            fin_q   <= 1'b1;
                        end
                    end
`ifdef OPR_TIMEOUT_EN
                    // A done on the last allowed cycle wins above.
                    else if (cnt_q == CNT_LAST) begin
                        err_q    <= 1'b1;
                        pend_q   <= '0;
                        active_q <= '0;
                        state_q  <= ST_DONE;
                        fin_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign opr_if.ready        = (state_q == ST_IDLE);
    assign opr_if.busy         = (state_q != ST_IDLE);
    assign opr_if.opr_start    = start_q;
    assign opr_if.opr_active   = active_q;
    assign opr_if.cur_opr      = cur_q;
    assign opr_if.opr_finished = fin_q;
`ifdef OPR_TIMEOUT_EN
    assign opr_if.opr_error    = err_q;
`else
    assign opr_if.opr_error    = 1'b0;
`endif

endmodule

// File: tb/tb_cache_opr_sequencer.sv
// Self-checking bench for cache_opr_sequencer: directed and random
// commands compared against a cycle-timeline model of the sequencer.
module tb_cache_opr_sequencer;

    localparam int N   = 8;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_opr_sequencer_if #(.NUM_OPR(N)) bus ();

    cache_opr_sequencer #(
        .NUM_OPR     (N),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .opr_if (bus)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;
    int exp_cur = 0;
    int dl[8];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: stage i (if masked) starts at cycle t, its done arrives
    // d[i] cycles later, and the next stage starts the cycle after.
    task automatic run_cmd(input logic [7:0] mask, input int d[8],
                           input bit noise, input logic [7:0] force_b,
                           input bit keep_valid);
        int st[8];
        int t;
        int fin;
        int cur;
        logic [7:0] es;
        logic [7:0] ea;
        logic [7:0] dn;
        t = 1;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                st[i] = t;
                t = t + d[i] + 1;
            end else begin
                st[i] = -1000;
            end
        end
        fin = t;
        bus.valid    = 1'b1;
        bus.opr_mask = mask;
        bus.opr_done = '0;
        step();
        for (int c = 1; c <= fin + 1; c++) begin
            es  = '0;
            ea  = '0;
            cur = exp_cur;
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) begin
                    if (c == st[i]) es[i] = 1'b1;
                    if (c > st[i] && c <= st[i] + d[i]) ea[i] = 1'b1;
                    if (c >= st[i]) cur = i;
                end
            end
            chk("start", bus.opr_start, es);
            chk("active", bus.opr_active, ea);
            chk("cur_opr", bus.cur_opr, cur);
            chk("finished", bus.opr_finished, c == fin);
            chk("ready", bus.ready, c == fin + 1);
            chk("busy", bus.busy, c <= fin);
            chk("error", bus.opr_error, 0);
            dn = '0;
            for (int i = 0; i < 8; i++) begin
                if (mask[i] && c == st[i] + d[i]) dn[i] = 1'b1;
            end
            if (noise) dn = dn | (8'($urandom) & ~ea);
            dn = dn | (force_b & ~ea);
            bus.opr_done = dn;
            if (keep_valid && c <= fin) begin
                bus.valid    = 1'($urandom);
                bus.opr_mask = 8'($urandom);
            end else begin
                bus.valid = 1'b0;
            end
            step();
        end
        bus.opr_done = '0;
        bus.valid    = 1'b0;
        exp_cur = cur;
    endtask

    initial begin
        rst          = 1'b1;
        bus.valid    = 1'b0;
        bus.opr_mask = '0;
        bus.opr_done = '0;
        step();
        step();
        chk("rst_start", bus.opr_start, 0);
        chk("rst_active", bus.opr_active, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fin", bus.opr_finished, 0);
        rst = 1'b0;
        step();
        chk("rst_ready", bus.ready, 1);
        chk("rst_cur", bus.cur_opr, 0);
        chk("rst_err", bus.opr_error, 0);

        // All stages, each done 3 cycles after start: finish at 33.
        for (int i = 0; i < 8; i++) dl[i] = 3;
        run_cmd(8'hFF, dl, 1'b0, 8'h00, 1'b0);

        // Sparse mask with noise on inactive done lines.
        for (int i = 0; i < 8; i++) dl[i] = 1 + (i % 3);
        run_cmd(8'b1010_0100, dl, 1'b1, 8'h00, 1'b1);

        // Empty mask: finish at cycle 1, no starts.
        run_cmd(8'h00, dl, 1'b0, 8'h00, 1'b0);

        // Stray done[1] while waiting on stage 0 (and in its ISSUE cycle).
        dl[0] = 5;
        dl[1] = 2;
        run_cmd(8'h03, dl, 1'b0, 8'h02, 1'b0);

`ifdef OPR_TIMEOUT_EN
        bus.valid    = 1'b1;
        bus.opr_mask = 8'h01;
        step();
        bus.valid = 1'b0;
        chk("tmo_start", bus.opr_start, 8'h01);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("tmo_active", bus.opr_active, 8'h01);
            chk("tmo_fin0", bus.opr_finished, 0);
            chk("tmo_err0", bus.opr_error, 0);
        end
        step();
        chk("tmo_fin", bus.opr_finished, 1);
        chk("tmo_err", bus.opr_error, 1);
        step();
        chk("tmo_ready", bus.ready, 1);
        chk("tmo_sticky", bus.opr_error, 1);
        exp_cur = 0;
        run_cmd(8'h00, dl, 1'b0, 8'h00, 1'b0);
`else
        bus.valid    = 1'b1;
        bus.opr_mask = 8'h01;
        step();
        bus.valid = 1'b0;
        chk("hold_start", bus.opr_start, 8'h01);
        for (int c = 2; c <= 21; c++) begin
            step();
            chk("hold_active", bus.opr_active, 8'h01);
            chk("hold_fin", bus.opr_finished, 0);
            chk("hold_err", bus.opr_error, 0);
        end
        bus.opr_done = 8'h01;
        step();
        bus.opr_done = '0;
        chk("hold_done", bus.opr_finished, 1);
        step();
        chk("hold_ready", bus.ready, 1);
        exp_cur = 0;
`endif

        // Reset while waiting on stage 3.
        bus.valid    = 1'b1;
        bus.opr_mask = 8'h08;
        step();
        bus.valid = 1'b0;
        chk("mid_start", bus.opr_start, 8'h08);
        step();
        chk("mid_active", bus.opr_active, 8'h08);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_active0", bus.opr_active, 0);
        chk("mid_start0", bus.opr_start, 0);
        chk("mid_cur0", bus.cur_opr, 0);
        chk("mid_busy0", bus.busy, 0);
        chk("mid_ready", bus.ready, 1);
        chk("mid_err0", bus.opr_error, 0);
        for (int c = 0; c < 3; c++) begin
            chk("mid_nofin", bus.opr_finished, 0);
            step();
        end
        exp_cur = 0;

        // Random commands.
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 8; i++) dl[i] = $urandom_range(1, 6);
            run_cmd(8'($urandom), dl, 1'($urandom), 8'h00, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
